// File: rtl/orb_frame_writer_pkg.sv
// rtl/orb_frame_writer_pkg.sv - shared constants, slot map and state type for the orbit frame writer
package orb_pkg;

    localparam int WORD_W      = 12;
    localparam int FRAME_WORDS = 2048;
    localparam int FAST_SLOTS  = 512;
    localparam int SLOW_SLOTS  = 1536;
    localparam int PTR_W       = 9;
    localparam int ADDR_W      = $clog2(FRAME_WORDS) + 1;

    localparam logic [1:0] FAST_LANE     = 2'b00;
    localparam logic [1:0] SLOW_SUB_LAST = 2'd2;

    localparam logic [PTR_W-1:0] FAST_PTR_LAST = PTR_W'(FAST_SLOTS - 1);
    localparam logic [PTR_W-1:0] SLOW_GRP_LAST = PTR_W'(SLOW_SLOTS / 3 - 1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } orb_state_e;

    function automatic logic [ADDR_W-2:0] fast_word(input logic [PTR_W-1:0] ptr);
        return {ptr, FAST_LANE};
    endfunction

    // Slow words occupy lanes 1..3 of each group of four.
    function automatic logic [ADDR_W-2:0] slow_word(input logic [PTR_W-1:0] grp,
                                                     input logic [1:0]       sub);
        return {grp, sub + 2'd1};
    endfunction

endpackage

// File: rtl/orb_frame_writer_arb.sv
// rtl/orb_frame_writer_arb.sv - fast/slow write-port arbiter with bounded fast bursts
module orb_wr_arb
    import orb_pkg::*;
#(
    parameter int FAST_BURST = 4
) (
    input  logic reset,
    input  logic iClkOrb,
    input  logic iEn,
    input  logic iClr,
    input  logic iFastReq,
    input  logic iSlowReq,
    input  logic iFastDone,
    input  logic iSlowDone,
    output logic oFastGnt,
    output logic oSlowGnt
);

    localparam int BW = $clog2(FAST_BURST + 1);

    logic [BW-1:0] burst_q;
    logic [BW-1:0] burst_d;
    logic          fast_elig;
    logic          slow_elig;
    logic          starve;

    always_comb begin
        fast_elig = iFastReq && !iFastDone;
        slow_elig = iSlowReq && !iSlowDone;
        starve    = (burst_q >= BW'(FAST_BURST)) && slow_elig;
        oFastGnt  = iEn && fast_elig && !starve;
        oSlowGnt  = iEn && slow_elig && (!fast_elig || starve);

        // Counts fast grants taken while slow was waiting.
        burst_d = burst_q;
        if (iClr || !iSlowReq || oSlowGnt) begin
            burst_d = '0;
        end else if (oFastGnt && (burst_q < BW'(FAST_BURST))) begin
            burst_d = burst_q + BW'(1);
        end
    end

    always_ff @(posedge iClkOrb or negedge reset) begin
        if (!reset) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end

endmodule

// File: rtl/orb_frame_writer.sv
// rtl/orb_frame_writer.sv - ping-pong frame RAM write scheduler for the orbit serializer
module orb_frame_writer
    import orb_pkg::*;
#(
    parameter int FAST_BURST = 4
) (
    input  logic              reset,
    input  logic              iClkOrb,
    input  logic              iSwitch,
    input  logic              iFastReq,
    input  logic [WORD_W-1:0] iFastData,
    output logic              oFastAck,
    input  logic              iSlowReq,
    input  logic [WORD_W-1:0] iSlowData,
    output logic              oSlowAck,
    output logic [ADDR_W-1:0] oWrAddr,
    output logic [WORD_W-1:0] oWrData,
    output logic              oWrEn,
    output logic              oFastDone,
    output logic              oSlowDone,
    output logic              oUnderrun,
    output logic [7:0]        oUnderrunCnt
);

    orb_state_e        state_q, state_d;
    logic              sw_q, sw_d;
    logic [PTR_W-1:0]  fptr_q, fptr_d;
    logic [PTR_W-1:0]  sgrp_q, sgrp_d;
    logic [1:0]        ssub_q, ssub_d;
    logic              fdone_q, fdone_d;
    logic              sdone_q, sdone_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;
    logic              und_pend_q, und_pend_d;
    logic              und_q, und_d;
    logic [7:0]        und_cnt_q, und_cnt_d;

    logic sw_edge;
    logic arb_en;
    logic fast_gnt;
    logic slow_gnt;

    // Acks are held off while reset is asserted so every output reads zero.
    assign sw_edge = iSwitch ^ sw_q;
    assign arb_en  = reset && (state_q == FILL) && !sw_edge;

    orb_wr_arb #(
        .FAST_BURST (FAST_BURST)
    ) u_arb (
        .reset     (reset),
        .iClkOrb   (iClkOrb),
        .iEn       (arb_en),
        .iClr      (sw_edge),
        .iFastReq  (iFastReq),
        .iSlowReq  (iSlowReq),
        .iFastDone (fdone_q),
        .iSlowDone (sdone_q),
        .oFastGnt  (fast_gnt),
        .oSlowGnt  (slow_gnt)
    );

    assign oFastAck = fast_gnt;
    assign oSlowAck = slow_gnt;

    always_comb begin
        state_d    = state_q;
        sw_d       = iSwitch;
        fptr_d     = fptr_q;
        sgrp_d     = sgrp_q;
        ssub_d     = ssub_q;
        fdone_d    = fdone_q;
        sdone_d    = sdone_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        und_pend_d = 1'b0;
        und_d      = und_pend_q;
        und_cnt_d  = und_cnt_q;

        if (und_pend_q && (und_cnt_q != 8'hFF)) begin
            und_cnt_d = und_cnt_q + 8'd1;
        end

        if (sw_edge) begin
            // Serializer took the half we were filling; retarget to the other one.
            und_pend_d = !(fdone_q && sdone_q);
            fptr_d     = '0;
            sgrp_d     = '0;
            ssub_d     = '0;
            fdone_d    = 1'b0;
            sdone_d    = 1'b0;
            state_d    = FILL;
        end else begin
            if (fast_gnt) begin
                wr_en_d   = 1'b1;
                wr_addr_d = {~sw_q, fast_word(fptr_q)};
                wr_data_d = iFastData;
                fptr_d    = fptr_q + PTR_W'(1);
                if (fptr_q == FAST_PTR_LAST) begin
                    fdone_d = 1'b1;
                end
            end else if (slow_gnt) begin
                wr_en_d   = 1'b1;
                wr_addr_d = {~sw_q, slow_word(sgrp_q, ssub_q)};
                wr_data_d = iSlowData;
                if (ssub_q == SLOW_SUB_LAST) begin
                    ssub_d = '0;
                    sgrp_d = sgrp_q + PTR_W'(1);
                    if (sgrp_q == SLOW_GRP_LAST) begin
                        sdone_d = 1'b1;
                    end
                end else begin
                    ssub_d = ssub_q + 2'd1;
                end
            end
            if (fdone_d && sdone_d) begin
                state_d = FULL;
            end
        end
    end

    always_ff @(posedge iClkOrb or negedge reset) begin
        if (!reset) begin
            state_q    <= FILL;
            sw_q       <= 1'b0;
            fptr_q     <= '0;
            sgrp_q     <= '0;
            ssub_q     <= '0;
            fdone_q    <= 1'b0;
            sdone_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            und_pend_q <= 1'b0;
            und_q      <= 1'b0;
            und_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            sw_q       <= sw_d;
            fptr_q     <= fptr_d;
            sgrp_q     <= sgrp_d;
            ssub_q     <= ssub_d;
            fdone_q    <= fdone_d;
            sdone_q    <= sdone_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            und_pend_q <= und_pend_d;
            und_q      <= und_d;
            und_cnt_q  <= und_cnt_d;
        end
    end

    assign oWrEn        = wr_en_q;
    assign oWrAddr      = wr_addr_q;
    assign oWrData      = wr_data_q;
    assign oFastDone    = fdone_q;
    assign oSlowDone    = sdone_q;
    assign oUnderrun    = und_q;
    assign oUnderrunCnt = und_cnt_q;

endmodule

// File: tb/tb_orb_frame_writer.sv
// tb/tb_orb_frame_writer.sv - scoreboard bench for orb_frame_writer
module tb_orb_frame_writer;

    localparam int FB = 4;

    logic        iClkOrb = 1'b0;
    logic        reset   = 1'b0;
    logic        iSwitch = 1'b0;
    logic        iFastReq = 1'b0;
    logic [11:0] iFastData = '0;
    logic        iSlowReq = 1'b0;
    logic [11:0] iSlowData = '0;
    logic        oFastAck, oSlowAck, oWrEn, oFastDone, oSlowDone, oUnderrun;
    logic [11:0] oWrAddr, oWrData;
    logic [7:0]  oUnderrunCnt;

    orb_frame_writer #(.FAST_BURST(FB)) dut (
        .reset        (reset),
        .iClkOrb      (iClkOrb),
        .iSwitch      (iSwitch),
        .iFastReq     (iFastReq),
        .iFastData    (iFastData),
        .oFastAck     (oFastAck),
        .iSlowReq     (iSlowReq),
        .iSlowData    (iSlowData),
        .oSlowAck     (oSlowAck),
        .oWrAddr      (oWrAddr),
        .oWrData      (oWrData),
        .oWrEn        (oWrEn),
        .oFastDone    (oFastDone),
        .oSlowDone    (oSlowDone),
        .oUnderrun    (oUnderrun),
        .oUnderrunCnt (oUnderrunCnt)
    );

    initial forever #5 iClkOrb = ~iClkOrb;

    int cyc = 0;
    always @(posedge iClkOrb) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          fc = 0, sc = 0, burst = 0, cnt_m = 0;
    logic        sw_reg = 1'b0;
    logic        sw_lvl = 1'b0;
    logic [23:0] wq[$];
    int          uq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_fast_ack"}, 32'(oFastAck), 0);
        chk({tag, "_slow_ack"}, 32'(oSlowAck), 0);
        chk({tag, "_wr_en"}, 32'(oWrEn), 0);
        chk({tag, "_wr_addr"}, 32'(oWrAddr), 0);
        chk({tag, "_wr_data"}, 32'(oWrData), 0);
        chk({tag, "_fast_done"}, 32'(oFastDone), 0);
        chk({tag, "_slow_done"}, 32'(oSlowDone), 0);
        chk({tag, "_underrun"}, 32'(oUnderrun), 0);
        chk({tag, "_underrun_cnt"}, 32'(oUnderrunCnt), 0);
    endtask

    // One clock of stimulus; reference behaviour is derived from word counts in the current half.
    task automatic step(input logic fr, input logic sr, input logic sw);
        logic        sw_edge_m, fel, sel, starve, efa, esa;
        logic [11:0] fd, sd, base;
        @(negedge iClkOrb);
        fd = 12'($urandom);
        sd = 12'($urandom);
        iFastReq  = fr;
        iFastData = fd;
        iSlowReq  = sr;
        iSlowData = sd;
        iSwitch   = sw;
        #1;
        sw_edge_m = (sw != sw_reg);
        fel       = fr && (fc < 512);
        sel       = sr && (sc < 1536);
        starve    = (burst >= FB) && sel;
        efa       = !sw_edge_m && fel && !starve;
        esa       = !sw_edge_m && sel && (!fel || starve);
        chk("fast_ack", 32'(oFastAck), 32'(efa));
        chk("slow_ack", 32'(oSlowAck), 32'(esa));
        base = sw_reg ? 12'h000 : 12'h800;
        if (sw_edge_m) begin
            if (!(fc == 512 && sc == 1536)) uq.push_back(cyc + 2);
        end else if (efa) begin
            wq.push_back({base + 12'(4 * fc), fd});
        end else if (esa) begin
            wq.push_back({base + 12'(4 * (sc / 3) + (sc % 3) + 1), sd});
        end
        @(posedge iClkOrb);
        if (sw_edge_m) begin
            fc = 0;
            sc = 0;
            burst = 0;
        end else begin
            if (!sr || esa) burst = 0;
            else if (efa) burst++;
            if (efa) fc++;
            if (esa) sc++;
        end
        sw_reg = sw;
    endtask

    task automatic do_reset();
        @(negedge iClkOrb);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("midreset");
        fc = 0; sc = 0; burst = 0; cnt_m = 0;
        sw_reg = 1'b0;
        sw_lvl = 1'b0;
        wq.delete();
        uq.delete();
        iSwitch = 1'b0; iFastReq = 1'b0; iSlowReq = 1'b0;
        repeat (2) @(negedge iClkOrb);
        #2;
        reset = 1'b1;
    endtask

    task automatic toggle_sw(input logic fr, input logic sr);
        sw_lvl = ~sw_lvl;
        step(fr, sr, sw_lvl);
    endtask

    // Monitor: writes, under-run pulses, counter and done flags.
    initial forever begin
        logic [23:0] e;
        logic        exp_u;
        @(negedge iClkOrb);
        if (reset === 1'b1) begin
            chk("wr_en", 32'(oWrEn), 32'(wq.size() != 0));
            if (wq.size() != 0) begin
                e = wq.pop_front();
                if (oWrEn) begin
                    chk("wr_addr", 32'(oWrAddr), 32'(e[23:12]));
                    chk("wr_data", 32'(oWrData), 32'(e[11:0]));
                end
            end
            while (uq.size() != 0 && uq[0] < cyc) void'(uq.pop_front());
            exp_u = (uq.size() != 0 && uq[0] == cyc);
            if (exp_u) begin
                void'(uq.pop_front());
                if (cnt_m < 255) cnt_m++;
            end
            chk("underrun", 32'(oUnderrun), 32'(exp_u));
            chk("underrun_cnt", 32'(oUnderrunCnt), 32'(cnt_m));
            chk("fast_done", 32'(oFastDone), 32'(fc == 512));
            chk("slow_done", 32'(oSlowDone), 32'(sc == 1536));
        end
    end

    initial begin
        iFastReq = 1'b1;
        iSlowReq = 1'b1;
        #1;
        chk_zero("reset");
        @(negedge iClkOrb);
        iFastReq = 1'b0;
        iSlowReq = 1'b0;
        #2;
        reset = 1'b1;

        repeat (1546) step(1'b0, 1'b1, sw_lvl);
        chk("slow_only_done", 32'(oSlowDone), 1);
        repeat (522) step(1'b1, 1'b0, sw_lvl);
        #1;
        chk("fast_only_both_done", 32'({oFastDone, oSlowDone}), 3);

        toggle_sw(1'b1, 1'b1);
        repeat (2048) step(1'b1, 1'b1, sw_lvl);
        #1;
        chk("fill_2048_both_done", 32'({oFastDone, oSlowDone}), 3);
        repeat (5) step(1'b1, 1'b1, sw_lvl);

        toggle_sw(1'b1, 1'b1);
        while (fc + sc < 100) step(1'b1, 1'b1, sw_lvl);
        toggle_sw(1'b0, 1'b1);
        repeat (10) step(1'b0, 1'b1, sw_lvl);

        repeat (3000) begin
            if ($urandom_range(199) == 0) sw_lvl = ~sw_lvl;
            step(1'($urandom_range(99) < 60), 1'($urandom_range(99) < 60), sw_lvl);
        end

        repeat (260) begin
            toggle_sw(1'b1, 1'b1);
            step(1'b1, 1'b1, sw_lvl);
        end
        repeat (3) step(1'b1, 1'b1, sw_lvl);
        #1;
        chk("underrun_cnt_saturated", 32'(oUnderrunCnt), 255);

        toggle_sw(1'b1, 1'b1);
        while (fc + sc < 700) step(1'b1, 1'b1, sw_lvl);
        do_reset();
        repeat (60) step(1'b1, 1'b1, sw_lvl);

        repeat (3) step(1'b0, 1'b0, sw_lvl);
        chk("write_queue_drained", 32'(wq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
